// File: rtl/tmds_decoder_dvi.sv
// -----------------------------------------------------------------------------
// tmds_decoder_dvi
//
// Decodes one DVI TMDS channel. It takes the 10-bit parallel symbols from an
// external 1:10 deserializer in the pixel clock domain. It finds the word
// boundary by hunting for runs of control tokens. Until a run is found, it
// asks the deserializer for bitslips. Once aligned, it recovers the 8-bit
// pixel data, the 2-bit control value and the display enable.
//
// Ports
//   i_pix_clk     in   1   pixel clock, all logic on the rising edge
//   i_rst         in   1   synchronous reset, active high
//   i_tmds        in   10  parallel TMDS symbol, bit 0 = first bit on the wire
//   o_data        out  8   decoded pixel data, valid when o_de = 1
//   o_ctrl        out  2   decoded control bits, valid when o_de = 0
//   o_de          out  1   display enable (1 = data symbol)
//   o_aligned     out  1   1 while the alignment FSM is in LOCKED
//   o_bitslip     out  1   one-cycle pulse: shift the word boundary by one bit
//   o_dbg_state   out  2   alignment FSM state (0 SEARCH, 1 SLIP, 2 LOCKED)
//   o_loss_count  out  8   LOCKED->SEARCH transitions, saturating
//                          (present only with TMDS_DECODER_LOSS_CNT_EN)
//
// Build option
//   TMDS_DECODER_LOSS_CNT_EN : adds o_loss_count. When the macro is undefined,
//                              the port and its counter are absent.
//
// Timing
//   i_tmds is registered once (stage 1). The FSM and the decoder both look at
//   the stage-1 symbol. The decoded outputs are registered (stage 2), so the
//   latency from i_tmds to the outputs is 2 cycles.
// -----------------------------------------------------------------------------
module tmds_decoder_dvi #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_WAIT      = 4,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [9:0] i_tmds,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_aligned,
    output logic       o_bitslip,
    output logic [1:0] o_dbg_state
`ifdef TMDS_DECODER_LOSS_CNT_EN
    ,
    output logic [7:0] o_loss_count
`endif
);

    // Each counter only needs to reach its parameter minus one before it
    // forces a state change. The +1 keeps the width at least 1 bit when a
    // parameter is 1.
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [9:0]        q1;
    logic [RUN_W-1:0]  run_cnt;
    logic [SRCH_W-1:0] search_cnt;
    logic [SLIP_W-1:0] slip_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic              is_tok;
    logic [1:0]        tok_ctrl;
    logic [7:0]        d_pre;
    logic [7:0]        dec_data;

    // Stage 1: capture the deserializer word.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) q1 <= '0;
        else       q1 <= i_tmds;
    end

    // Control token recognition on the stage-1 symbol.
    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (q1)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_tok   = 1'b0;
        endcase
    end

    // Data decode. Bit 9 undoes the DC-balance inversion. Bit 8 selects
    // between the XOR and XNOR transition-minimising chains.
    always_comb begin
        d_pre       = q1[9] ? ~q1[7:0] : q1[7:0];
        dec_data    = '0;
        dec_data[0] = d_pre[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = q1[8] ? (d_pre[i] ^ d_pre[i-1]) : ~(d_pre[i] ^ d_pre[i-1]);
        end
    end

    // Alignment FSM, next-state logic. If a run completes in the same cycle
    // as the search timeout, the lock wins and no slip is issued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH: begin
                if (is_tok && run_cnt == RUN_LAST) state_nxt = ST_LOCKED;
                else if (search_cnt == SRCH_LAST)  state_nxt = ST_SLIP;
            end
            ST_SLIP: begin
                if (slip_cnt == SLIP_LAST) state_nxt = ST_SEARCH;
            end
            ST_LOCKED: begin
                if (!is_tok && idle_cnt == IDLE_LAST) state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // State register and counters. Every counter clears whenever the FSM
    // changes state, so no counter can ever wrap.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            search_cnt <= '0;
            slip_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_SEARCH && state_nxt == ST_SEARCH) begin
                run_cnt    <= is_tok ? run_cnt + 1'b1 : '0;
                search_cnt <= search_cnt + 1'b1;
            end else begin
                run_cnt    <= '0;
                search_cnt <= '0;
            end

            if (state == ST_SLIP && state_nxt == ST_SLIP) slip_cnt <= slip_cnt + 1'b1;
            else                                          slip_cnt <= '0;

            if (state == ST_LOCKED && state_nxt == ST_LOCKED) idle_cnt <= is_tok ? '0 : idle_cnt + 1'b1;
            else                                              idle_cnt <= '0;
        end
    end

    // Stage 2: registered decode. The outputs are forced to zero unless the
    // FSM is LOCKED. On a data symbol, o_ctrl keeps its last token value.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_ctrl <= '0;
            o_de   <= 1'b0;
        end else if (state == ST_LOCKED) begin
            if (is_tok) begin
                o_data <= '0;
                o_ctrl <= tok_ctrl;
                o_de   <= 1'b0;
            end else begin
                o_data <= dec_data;
                o_de   <= 1'b1;
            end
        end else begin
            o_data <= '0;
            o_ctrl <= '0;
            o_de   <= 1'b0;
        end
    end

    // The bitslip pulse is the first cycle of SLIP. Reset returns the FSM to
    // SEARCH, which cancels any slip that is pending.
    assign o_bitslip   = (state == ST_SLIP) && (slip_cnt == '0);
    assign o_aligned   = (state == ST_LOCKED);
    assign o_dbg_state = state;

`ifdef TMDS_DECODER_LOSS_CNT_EN
    always_ff @(posedge i_pix_clk) begin
        if (i_rst)
            o_loss_count <= '0;
        else if (state == ST_LOCKED && state_nxt == ST_SEARCH && o_loss_count != 8'hFF)
            o_loss_count <= o_loss_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder_dvi
//
// Self-checking bench for tmds_decoder_dvi.
// - Data symbols come from a TMDS encoder model: random byte, random XOR/XNOR
//   chain and random inversion. The expected output is the original byte.
// - Control tokens are looked up in a table.
// - Alignment timing is checked against cycle counts worked out from the
//   parameters.
// -----------------------------------------------------------------------------
module tb_tmds_decoder_dvi;
    localparam int CTRL_RUN       = 8;
    localparam int SEARCH_TIMEOUT = 1024;
    localparam int SLIP_WAIT      = 4;
    localparam int LOCK_TIMEOUT   = 4096;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds = '0;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de, o_aligned, o_bitslip;
    logic [1:0] o_dbg_state;
`ifdef TMDS_DECODER_LOSS_CNT_EN
    logic [7:0] o_loss_count;
`endif

    always #5 clk = ~clk;

    tmds_decoder_dvi #(
        .CTRL_RUN(CTRL_RUN), .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_WAIT(SLIP_WAIT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .i_pix_clk(clk), .i_rst(rst), .i_tmds(tmds),
        .o_data(o_data), .o_ctrl(o_ctrl), .o_de(o_de),
        .o_aligned(o_aligned), .o_bitslip(o_bitslip),
        .o_dbg_state(o_dbg_state)
`ifdef TMDS_DECODER_LOSS_CNT_EN
        , .o_loss_count(o_loss_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] exp_q[$];            // {de, ctrl[1:0], data[7:0]}
    logic [1:0]  last_ctrl;
    logic [9:0]  tokens[4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [9:0] encode(input logic [7:0] b, input logic use_xnor, input logic inv);
        logic [7:0] qm;
        qm    = '0;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        return {inv, ~use_xnor, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] v, input int r);
        logic [9:0] x;
        x = v;
        for (int i = 0; i < r; i++) x = {x[8:0], x[9]};
        return x;
    endfunction

    task automatic push_expected(input logic [9:0] sym, input logic [7:0] src);
        logic       hit;
        logic [1:0] c;
        hit = 1'b0;
        c   = 2'b00;
        for (int k = 0; k < 4; k++) if (sym == tokens[k]) begin hit = 1'b1; c = 2'(k); end
        if (hit) begin
            last_ctrl = c;
            exp_q.push_back({1'b0, c, 8'h00});
        end else begin
            exp_q.push_back({1'b1, last_ctrl, src});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_de",      32'(o_de),      32'd0);
        check("rst_ctrl",    32'(o_ctrl),    32'd0);
        check("rst_data",    32'(o_data),    32'd0);
        check("rst_aligned", 32'(o_aligned), 32'd0);
        check("rst_bitslip", 32'(o_bitslip), 32'd0);
`ifdef TMDS_DECODER_LOSS_CNT_EN
        check("rst_loss", 32'(o_loss_count), 32'd0);
`endif
        rst = 1'b0;
    endtask

    // The outputs seen after this tick belong to the symbol driven one call
    // earlier. That is the front of the queue.
    task automatic send(input logic [9:0] sym, input logic [7:0] src);
        logic [10:0] e;
        tmds = sym;
        tick();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_de",   32'(o_de),   32'(e[10]));
            check("sb_ctrl", 32'(o_ctrl), 32'(e[9:8]));
            check("sb_data", 32'(o_data), 32'(e[7:0]));
        end
        push_expected(sym, src);
    endtask

    // Lock from reset with aligned tokens. Lock is expected on tick CTRL_RUN+1.
    task automatic relock(input logic [9:0] tok, input string tag);
        tmds = tok;
        for (int n = 1; n <= CTRL_RUN + 1; n++) begin
            tick();
            check({tag, "_aligned"}, 32'(o_aligned), 32'(n >= CTRL_RUN + 1));
            check({tag, "_bitslip"}, 32'(o_bitslip), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        int         rot, slips, last_slip, lock_tick, t;

        // Plain token stream from reset.
        tmds = tokens[0];
        do_reset();
        relock(tokens[0], "t1");
        check("t1_de",   32'(o_de),   32'd0);
        check("t1_ctrl", 32'(o_ctrl), 32'd0);

        // Directed decodes, then the token cycle.
        last_ctrl = 2'b00;
        exp_q.delete();
        send(tokens[0], 8'h00);
        send(10'h100, 8'h00);
        send(10'h2FF, 8'hFE);
        for (int k = 0; k < 4; k++) send(tokens[k], 8'h00);

        // Random locked traffic.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                send(tokens[$urandom_range(0, 3)], 8'h00);
            end else begin
                b = 8'($urandom);
                send(encode(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), b);
            end
        end
        send(tokens[0], 8'h00);
        exp_q.delete();
        check("sb_still_locked", 32'(o_aligned), 32'd1);

        // Data-only stream until lock drops.
        tmds = 10'h100;
        for (int j = 1; j <= LOCK_TIMEOUT + 2; j++) begin
            tick();
            check("t5_aligned", 32'(o_aligned), 32'(j <= LOCK_TIMEOUT));
            check("t5_de",      32'(o_de),      32'(j >= 2 && j <= LOCK_TIMEOUT + 1));
        end
        check("t5_data", 32'(o_data), 32'd0);
        check("t5_ctrl", 32'(o_ctrl), 32'd0);
`ifdef TMDS_DECODER_LOSS_CNT_EN
        check("t5_loss", 32'(o_loss_count), 32'd1);
`endif

        // Rotated token stream. The deserializer model rotates one more bit
        // per slip, so 7 slips take the rotation from 3 back to 0.
        rot       = 3;
        tmds      = rotl(tokens[0], rot);
        do_reset();
        slips     = 0;
        last_slip = 0;
        lock_tick = 0;
        t         = 0;
        while (lock_tick == 0 && t < 8 * (SEARCH_TIMEOUT + SLIP_WAIT) + 100) begin
            t++;
            tmds = rotl(tokens[0], rot);
            tick();
            if (o_bitslip) begin
                slips++;
                if (slips == 1) check("t4_first_slip", 32'(t), 32'(SEARCH_TIMEOUT));
                else            check("t4_slip_gap", 32'(t - last_slip), 32'(SEARCH_TIMEOUT + SLIP_WAIT));
                last_slip = t;
                rot = (rot + 1) % 10;
            end
            if (o_aligned) lock_tick = t;
        end
        check("t4_slip_count", 32'(slips), 32'd7);
        check("t4_lock_tick", 32'(lock_tick), 32'(last_slip + SLIP_WAIT + CTRL_RUN));

        // Reset on the bitslip cycle.
        rot  = 3;
        tmds = rotl(tokens[0], rot);
        do_reset();
        t = 0;
        while (!o_bitslip && t < SEARCH_TIMEOUT + 10) begin
            tick();
            t++;
        end
        check("t6_slip_seen", 32'(o_bitslip), 32'd1);
        rst = 1'b1;
        tick();
        check("t6a_bitslip", 32'(o_bitslip), 32'd0);
        check("t6a_aligned", 32'(o_aligned), 32'd0);
        check("t6a_de",      32'(o_de),      32'd0);
        check("t6a_data",    32'(o_data),    32'd0);
        check("t6a_ctrl",    32'(o_ctrl),    32'd0);
        rst = 1'b0;
        relock(tokens[0], "t6a_relock");

        // Reset while locked, with o_ctrl holding a non-zero value.
        tmds = tokens[3];
        tick();
        tick();
        tick();
        check("t6b_ctrl_pre", 32'(o_ctrl), 32'd3);
        rst = 1'b1;
        tick();
        check("t6b_aligned", 32'(o_aligned), 32'd0);
        check("t6b_ctrl",    32'(o_ctrl),    32'd0);
        check("t6b_de",      32'(o_de),      32'd0);
        check("t6b_bitslip", 32'(o_bitslip), 32'd0);
        rst = 1'b0;
        relock(tokens[3], "t6b_relock");

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the stimulus is bounded, so this only fires if simulation stalls.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
